// File: rtl/bounded_updown_counter_if.sv
// Bus bundle for bounded_updown_counter.
//   master : drives the control/bound inputs and receives the counter outputs
//   slave  : the counter side
// Signals: enable, upcount, mode[1:0], lo, hi, load, load_value (to counter);
//          out, dir, at_min, at_max, bound_evt, bound_err (from counter).
interface bounded_updown_counter_if #(
  parameter int unsigned WIDTH = 5
);
  logic             enable;
  logic             upcount;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] out;
  logic             dir;
  logic             at_min;
  logic             at_max;
  logic             bound_evt;
  logic             bound_err;

  modport master (
    output enable, upcount, mode, lo, hi, load, load_value,
    input  out, dir, at_min, at_max, bound_evt, bound_err
  );

  modport slave (
    input  enable, upcount, mode, lo, hi, load, load_value,
    output out, dir, at_min, at_max, bound_evt, bound_err
  );
endinterface

// File: rtl/bounded_updown_counter.sv
// Up/down counter with runtime bounds [lo, hi], synchronous load and three
// boundary modes (wrap, saturate, bounce).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (out=0, dir=1, bound_evt=0)
//   bus   : slave modport of bounded_updown_counter_if carrying the controls,
//           bounds, load path and the out/dir/at_min/at_max/bound_evt/bound_err
//           outputs. out, dir and bound_evt are registered; the flags are
//           combinational on out, lo and hi.
module bounded_updown_counter #(
  parameter int unsigned WIDTH = 5
) (
  input logic                     clk,
  input logic                     reset,
  bounded_updown_counter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_BOUNCE   = 2'b10,
    MODE_SAT_ALT  = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_out;
  logic             r_dir;
  logic             r_evt;

  logic [WIDTH-1:0] w_out_nxt;
  logic             w_dir_nxt;
  logic             w_evt_nxt;
  logic             w_bound_err;
  logic             w_bounce;
  mode_e            w_mode;

  assign w_mode      = mode_e'(bus.mode);
  assign w_bounce    = (w_mode == MODE_BOUNCE);
  assign w_bound_err = (bus.lo > bus.hi);

  always_comb begin
    w_out_nxt = r_out;
    w_dir_nxt = r_dir;
    w_evt_nxt = 1'b0;

    if (bus.load) begin
      w_out_nxt = bus.load_value;
      w_dir_nxt = bus.upcount;
    end else if (bus.enable) begin
      // Outside bounce the direction simply tracks upcount; in bounce it is
      // owned by the reversal logic below.
      if (!w_bounce) begin
        w_dir_nxt = bus.upcount;
      end

      if (w_bound_err) begin
        w_out_nxt = r_out;
      end else if (r_out > bus.hi) begin
        w_out_nxt = bus.hi;
      end else if (r_out < bus.lo) begin
        w_out_nxt = bus.lo;
      end else if (w_bounce) begin
        if (bus.lo == bus.hi) begin
          // Single-point range: nowhere to move, so only reverse.
          w_dir_nxt = ~r_dir;
          w_evt_nxt = 1'b1;
        end else if (r_dir && (r_out == bus.hi)) begin
          w_dir_nxt = 1'b0;
          w_out_nxt = bus.hi - ONE;
          w_evt_nxt = 1'b1;
        end else if (!r_dir && (r_out == bus.lo)) begin
          w_dir_nxt = 1'b1;
          w_out_nxt = bus.lo + ONE;
          w_evt_nxt = 1'b1;
        end else begin
          w_out_nxt = r_dir ? (r_out + ONE) : (r_out - ONE);
        end
      end else if (bus.upcount) begin
        if (r_out == bus.hi) begin
          if (w_mode == MODE_WRAP) begin
            w_out_nxt = bus.lo;
            w_evt_nxt = 1'b1;
          end
        end else begin
          w_out_nxt = r_out + ONE;
        end
      end else begin
        if (r_out == bus.lo) begin
          if (w_mode == MODE_WRAP) begin
            w_out_nxt = bus.hi;
            w_evt_nxt = 1'b1;
          end
        end else begin
          w_out_nxt = r_out - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
      r_dir <= 1'b1;
      r_evt <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      r_dir <= w_dir_nxt;
      r_evt <= w_evt_nxt;
    end
  end

  assign bus.out       = r_out;
  assign bus.dir       = r_dir;
  assign bus.bound_evt = r_evt;
  assign bus.at_min    = (r_out == bus.lo);
  assign bus.at_max    = (r_out == bus.hi);
  assign bus.bound_err = w_bound_err;

endmodule

// File: tb/tb_bounded_updown_counter.sv
module tb_bounded_updown_counter;

  localparam int unsigned WIDTH = 5;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  bounded_updown_counter_if #(.WIDTH(WIDTH)) bus ();

  bounded_updown_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_out_sat [5] = '{5, 4, 4, 4, 4};
  int exp_min_sat [5] = '{0, 1, 1, 1, 1};
  int exp_out_bnc [8] = '{3, 4, 5, 4, 3, 2, 3, 4};
  int exp_evt_bnc [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
  int exp_dir_bnc [8] = '{1, 1, 1, 0, 0, 0, 1, 1};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.upcount    = 1'b1;
    bus.mode       = 2'b00;
    bus.lo         = 5'd0;
    bus.hi         = 5'd31;
    bus.load       = 1'b0;
    bus.load_value = 5'd0;
    #12;
    check("rst_out", 32'(bus.out), 0);
    check("rst_dir", 32'(bus.dir), 1);
    check("rst_evt", 32'(bus.bound_evt), 0);
    check("rst_at_min", 32'(bus.at_min), 1);
    check("rst_bound_err", 32'(bus.bound_err), 0);
    reset = 1'b0;
    @(negedge clk);

    // Wrap up across the full range
    bus.enable = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      step();
      check("wrap_out", 32'(bus.out), 32'(i % 32));
      check("wrap_evt", 32'(bus.bound_evt), (i == 32) ? 1 : 0);
    end

    // Saturate down
    @(negedge clk);
    bus.enable = 1'b0; bus.load = 1'b1; bus.load_value = 5'd6;
    bus.lo = 5'd4; bus.hi = 5'd10; bus.mode = 2'b01; bus.upcount = 1'b0;
    step();
    check("sat_load_out", 32'(bus.out), 6);
    check("sat_load_dir", 32'(bus.dir), 0);
    @(negedge clk);
    bus.load = 1'b0; bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("sat_out", 32'(bus.out), 32'(exp_out_sat[i]));
      check("sat_at_min", 32'(bus.at_min), 32'(exp_min_sat[i]));
      check("sat_evt", 32'(bus.bound_evt), 0);
    end

    // Bounce between 2 and 5; upcount deliberately low to show it is ignored
    @(negedge clk);
    bus.enable = 1'b0; bus.load = 1'b1; bus.load_value = 5'd2; bus.upcount = 1'b1;
    bus.lo = 5'd2; bus.hi = 5'd5; bus.mode = 2'b10;
    step();
    check("bnc_load_out", 32'(bus.out), 2);
    @(negedge clk);
    bus.load = 1'b0; bus.enable = 1'b1; bus.upcount = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("bnc_out", 32'(bus.out), 32'(exp_out_bnc[i]));
      check("bnc_evt", 32'(bus.bound_evt), 32'(exp_evt_bnc[i]));
      check("bnc_dir", 32'(bus.dir), 32'(exp_dir_bnc[i]));
    end

    // Load and enable gap: from 4 count up in wrap mode
    @(negedge clk);
    bus.mode = 2'b00; bus.lo = 5'd0; bus.hi = 5'd31; bus.upcount = 1'b1;
    step(); check("gap_up1", 32'(bus.out), 5);
    step(); check("gap_up2", 32'(bus.out), 6);
    @(negedge clk);
    bus.enable = 1'b0;
    step(); check("gap_hold1", 32'(bus.out), 6);
    step(); check("gap_hold2", 32'(bus.out), 6);
    @(negedge clk);
    bus.enable = 1'b1; bus.load = 1'b1; bus.load_value = 5'd20;
    step(); check("load_over_enable", 32'(bus.out), 20);
    @(negedge clk);
    bus.load = 1'b0;

    // Out-of-range clamp, then bound error
    bus.hi = 5'd12;
    step();
    check("clamp_out", 32'(bus.out), 12);
    check("clamp_evt", 32'(bus.bound_evt), 0);
    check("clamp_at_max", 32'(bus.at_max), 1);
    @(negedge clk);
    bus.lo = 5'd15;
    #1;
    check("err_comb", 32'(bus.bound_err), 1);
    step();
    check("err_hold1", 32'(bus.out), 12);
    check("err_evt", 32'(bus.bound_evt), 0);
    step();
    check("err_hold2", 32'(bus.out), 12);
    @(negedge clk);
    bus.load = 1'b1; bus.load_value = 5'd9;
    step();
    check("err_load", 32'(bus.out), 9);

    // Async reset mid-count in bounce mode (degenerate range at 17 raises an event)
    @(negedge clk);
    bus.load_value = 5'd17; bus.lo = 5'd17; bus.hi = 5'd17; bus.mode = 2'b10;
    bus.upcount = 1'b1;
    step();
    check("deg_load", 32'(bus.out), 17);
    @(negedge clk);
    bus.load = 1'b0;
    step();
    check("deg_out", 32'(bus.out), 17);
    check("deg_dir", 32'(bus.dir), 0);
    check("deg_evt", 32'(bus.bound_evt), 1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_out", 32'(bus.out), 0);
    check("arst_dir", 32'(bus.dir), 1);
    check("arst_evt", 32'(bus.bound_evt), 0);
    @(negedge clk);
    reset = 1'b0; bus.lo = 5'd0; bus.hi = 5'd31;
    step(); check("resume1", 32'(bus.out), 1);
    step(); check("resume2", 32'(bus.out), 2);

    // Reset release with lo above zero clamps first
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0; bus.lo = 5'd3;
    step(); check("rel_clamp", 32'(bus.out), 3);
    step(); check("rel_step", 32'(bus.out), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
